// File: rtl/zx_pkg.sv
// Shared Spectrum-core types: CPU turbo level encoding and small elaboration helpers.
package zx_pkg;

   typedef logic [2:0] turbo_level_t;

   localparam turbo_level_t TURBO_3M5 = 3'd0;
   localparam turbo_level_t TURBO_7M  = 3'd1;
   localparam turbo_level_t TURBO_14M = 3'd2;
   localparam turbo_level_t TURBO_28M = 3'd3;
   localparam turbo_level_t TURBO_56M = 3'd4;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running divider producing the fixed 28/7 MHz and PSG strobes plus the
// raw turbo posedge/negedge strobes for the level currently in effect.
module ce_divider
   import zx_pkg::*;
#(
   parameter int unsigned LEVELS       = 5,
   parameter int unsigned PSG_DIV_LOG2 = 6
) (
   input  logic         clk_sys_i,
   input  logic         reset_n_i,
   input  turbo_level_t turbo_cur_i,
   output logic         ce_28m_o,
   output logic         ce_7mp_o,
   output logic         ce_7mn_o,
   output logic         ce_psg_o,
   output logic         tp_o,
   output logic         tn_o
);

   localparam int unsigned CW = max_u(LEVELS, PSG_DIV_LOG2) + 1;

   logic [CW-1:0]     cnt_q;
   logic [LEVELS-1:0] mask;
   logic [LEVELS-1:0] low;
   logic              tp_d;
   logic              tn_d;

   // Level L keeps the low LEVELS-L count bits, so its period is 2^(LEVELS-L).
   always_comb begin
      mask = {LEVELS{1'b1}} >> turbo_cur_i;
      low  = cnt_q[LEVELS-1:0] & mask;
      tp_d = (low == '0);
      tn_d = (low == (mask ^ (mask >> 1)));
   end

   always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_q    <= '0;
         ce_28m_o <= 1'b0;
         ce_7mp_o <= 1'b0;
         ce_7mn_o <= 1'b0;
         ce_psg_o <= 1'b0;
         tp_o     <= 1'b0;
         tn_o     <= 1'b0;
      end else begin
         cnt_q    <= cnt_q + 1'b1;
         ce_28m_o <= (cnt_q[1:0] == 2'b00);
         ce_7mp_o <= (cnt_q[3:0] == 4'b0000);
         ce_7mn_o <= (cnt_q[3:0] == 4'b1000);
         ce_psg_o <= (cnt_q[PSG_DIV_LOG2-1:0] == '0);
         tp_o     <= tp_d;
         tn_o     <= tn_d;
      end
   end

endmodule

// File: rtl/turbo_ce_gen.sv
// Clock-enable generator and CPU turbo controller: selects contended or turbo
// CPU strobes, stalls the CPU across speed changes, pause and SDRAM waits.
module turbo_ce_gen
   import zx_pkg::*;
#(
   parameter int unsigned LEVELS          = 5,
   parameter int unsigned MAX_LEVEL       = 4,
   parameter int unsigned PSG_DIV_LOG2    = 6,
   parameter int unsigned TIMEOUT_W       = 2,
   parameter int unsigned WAIT_LEVEL      = 3,
   parameter int unsigned TAPE_WAIT_LEVEL = 2
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [2:0] turbo_req,
   input  logic       tape_force,
   input  logic       tape_active,
   input  logic       pause,
   input  logic       ram_ready,
   input  logic       ula_ce_p,
   input  logic       ula_ce_n,
   output logic       ce_28m,
   output logic       ce_7mp,
   output logic       ce_7mn,
   output logic       ce_psg,
   output logic       ce_cpu_p,
   output logic       ce_cpu_n,
   output logic       ce_cpu,
   output logic       cpu_en,
   output logic [2:0] turbo_cur,
   output logic       switching
);

   localparam turbo_level_t MAX_L       = turbo_level_t'(MAX_LEVEL);
   localparam turbo_level_t WAIT_L      = turbo_level_t'(WAIT_LEVEL);
   localparam turbo_level_t TAPE_WAIT_L = turbo_level_t'(TAPE_WAIT_LEVEL);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } ctrl_state_t;

   ctrl_state_t          state_q, state_d;
   turbo_level_t         turbo_cur_q, turbo_cur_d;
   logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
   turbo_level_t         req_eff;
   logic                 tp, tn;
   logic                 cpu_p, cpu_n;

   ce_divider #(
      .LEVELS      (LEVELS),
      .PSG_DIV_LOG2(PSG_DIV_LOG2)
   ) u_div (
      .clk_sys_i  (clk_sys),
      .reset_n_i  (reset_n),
      .turbo_cur_i(turbo_cur_q),
      .ce_28m_o   (ce_28m),
      .ce_7mp_o   (ce_7mp),
      .ce_7mn_o   (ce_7mn),
      .ce_psg_o   (ce_psg),
      .tp_o       (tp),
      .tn_o       (tn)
   );

   always_comb begin
      req_eff = tape_force ? MAX_L : ((turbo_req > MAX_L) ? MAX_L : turbo_req);
      cpu_p   = (turbo_cur_q == TURBO_3M5) ? ula_ce_p : tp;
      cpu_n   = (turbo_cur_q == TURBO_3M5) ? ula_ce_n : tn;
   end

   // Settle counting runs alongside the run/stall decision on every cpu_n.
   always_comb begin
      state_d     = state_q;
      turbo_cur_d = turbo_cur_q;
      timeout_d   = timeout_q;
      if (cpu_n) begin
         if (timeout_q != '0) timeout_d = timeout_q + 1'b1;
         if (req_eff != turbo_cur_q) begin
            state_d     = ST_STALL;
            timeout_d   = TIMEOUT_W'(1);
            turbo_cur_d = req_eff;
         end else if (pause) begin
            state_d = ST_STALL;
         end else if (state_q == ST_STALL && timeout_q == '0 && ram_ready) begin
            state_d = ST_RUN;
         end else if (turbo_cur_q >= WAIT_L && !ram_ready) begin
            state_d = ST_STALL;
         end else if (turbo_cur_q >= TAPE_WAIT_L && !ram_ready && tape_active) begin
            state_d = ST_STALL;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         turbo_cur_q <= TURBO_3M5;
         timeout_q   <= '0;
      end else begin
         state_q     <= state_d;
         turbo_cur_q <= turbo_cur_d;
         timeout_q   <= timeout_d;
      end
   end

   assign cpu_en    = (state_q == ST_RUN);
   assign ce_cpu_p  = cpu_en & cpu_p;
   assign ce_cpu_n  = cpu_en & cpu_n;
   assign ce_cpu    = cpu_en & tp;
   assign turbo_cur = turbo_cur_q;
   assign switching = (timeout_q != '0);

endmodule

// File: doc/turbo_ce_gen.md
Name: turbo_ce_gen

Overview:
- Parametrised clock-enable generator and CPU turbo controller for the Spectrum core.
- Derives the fixed 28/7/1.75 MHz strobes and a CPU enable pair whose divide ratio is switchable from 3.5 MHz up to clk_sys/2.
- On a speed change it stalls the CPU cleanly, and at high speeds it inserts SDRAM wait stalls.
- Sits between the PLL and the T80pa/ULA/PSG; takes contended ULA strobes for the base speed.

Parameters:
- LEVELS, 5, number of speed levels; level L divides clk_sys by 2^(LEVELS-L).
- MAX_LEVEL, 4, highest level accepted; larger requests are clamped to it.
- PSG_DIV_LOG2, 6, log2 of the clk_sys/ce_psg ratio.
- TIMEOUT_W, 2, width of the post-switch settle counter.
- WAIT_LEVEL, 3, lowest level at which ram_ready stalls the CPU unconditionally.
- TAPE_WAIT_LEVEL, 2, lowest level at which ram_ready stalls the CPU while tape_active=1.

Ports:
- clk_sys  in  1  system clock (112 MHz nominal).
- reset_n  in  1  asynchronous active-low reset.
- turbo_req  in  3  requested level; 0 = 3.5 MHz contended.
- tape_force  in  1  forces the effective request to MAX_LEVEL (fast tape load).
- tape_active  in  1  tape engine is streaming.
- pause  in  1  freezes the CPU (OSD/DMA).
- ram_ready  in  1  SDRAM idle.
- ula_ce_p  in  1  contended CPU posedge strobe from video.
- ula_ce_n  in  1  contended CPU negedge strobe from video.
- ce_28m  out  1  1-cycle strobe every 4 clk.
- ce_7mp  out  1  7 MHz strobe, first half-period.
- ce_7mn  out  1  7 MHz strobe, second half-period.
- ce_psg  out  1  1-cycle strobe every 2^PSG_DIV_LOG2 clk.
- ce_cpu_p  out  1  gated CPU posedge enable.
- ce_cpu_n  out  1  gated CPU negedge enable.
- ce_cpu  out  1  gated uncontended turbo posedge strobe (feeds FDC/tape).
- cpu_en  out  1  CPU run gate.
- turbo_cur  out  3  level currently in effect.
- switching  out  1  settle counter is non-zero.

Behaviour:
- Reset (asynchronous): counter=0, all strobes 0, cpu_en=1, turbo_cur=0, timeout=0.
- Counter:
  - Free-running, width max(LEVELS,PSG_DIV_LOG2)+1, +1 every clk_sys, wraps naturally.
  - All strobes are registered from the counter value, so they appear one cycle after the count value is reached.
- Fixed strobes:
  - ce_28m when cnt[1:0]==0.
  - ce_7mp when cnt[3]==0 and cnt[2:0]==0.
  - ce_7mn when cnt[3]==1 and cnt[2:0]==0.
  - ce_psg when cnt[PSG_DIV_LOG2-1:0]==0.
- Turbo strobes:
  - mask = {LEVELS{1}} >> turbo_cur.
  - tp when (cnt & mask)==0.
  - tn when (cnt & mask)==(mask ^ (mask>>1)), i.e. at the half-period.
- Strobe selection:
  - turbo_cur==0: cpu_p/cpu_n = ula_ce_p/ula_ce_n.
  - Otherwise: cpu_p/cpu_n = tp/tn.
  - ce_cpu_p = cpu_en & cpu_p; ce_cpu_n = cpu_en & cpu_n; ce_cpu = cpu_en & tp.
- Effective request:
  - req_eff = tape_force ? MAX_LEVEL : min(turbo_req, MAX_LEVEL).
- Control update happens only on cycles where cpu_n=1 (ungated). Priority is highest first:
  1. timeout!=0: timeout increments and wraps to 0 after 2^TIMEOUT_W-1 strobes. This applies in parallel with rules 2–6.
  2. req_eff!=turbo_cur: cpu_en<=0, timeout<=1, turbo_cur<=req_eff.
  3. pause: cpu_en<=0.
  4. !cpu_en & timeout==0 & ram_ready: cpu_en<=1.
  5. turbo_cur>=WAIT_LEVEL & !ram_ready: cpu_en<=0.
  6. turbo_cur>=TAPE_WAIT_LEVEL & !ram_ready & tape_active: cpu_en<=0.
- Resume path: an SDRAM stall resumes through rule 4 on the next cpu_n with ram_ready=1. Pause resumes the same way once pause=0.
- A request change arriving during settle restarts settle: timeout=1, new level.
- Mid-cycle level change: the new mask applies from the next clock. cpu_en is 0 then, so no partial CPU strobe escapes.
- switching = (timeout!=0).
- turbo_cur never exceeds MAX_LEVEL.

Decomposition:
- Shared package (zx_pkg) holds:
  - typedef turbo_level_t (3 bits).
  - Constants TURBO_3M5=0, TURBO_7M=1, TURBO_14M=2, TURBO_28M=3, TURBO_56M=4.
- Sub-module ce_divider: counter plus registered fixed and turbo strobes, with turbo_cur as its input.
- Control FSM stays in the top.

Test Plan:
- Reset release, turbo_req=0, ula strobes tied to a 1-in-32 pattern:
  - ce_28m period 4, ce_7mp/ce_7mn 8 clk apart with period 16, ce_psg period 64.
  - ce_cpu_p equals ula_ce_p, delayed by 0 clk.
- turbo_req 0→2 (ula strobes at 1-in-32, as in the previous scenario):
  - First cpu_n: turbo_cur=2 and cpu_en=0.
  - 3 further cpu_n strobes: switching=0.
  - Next cpu_n with ram_ready=1: cpu_en=1.
  - Afterwards ce_cpu_p has period 8 and ce_cpu_n is offset 4.
- Level 4 with ram_ready pulsed low for 10 clk: cpu_en=0 on the first cpu_n inside the low window, back to 1 on the first cpu_n after it; no ce_cpu_p during the stall.
- Level 2 with ram_ready low: tape_active=0 keeps cpu_en=1; tape_active=1 drops cpu_en to 0.
- tape_force=1 at level 1: turbo_cur→4 through settle. With turbo_req=7 and MAX_LEVEL=3: turbo_cur=3.
- Asynchronous reset asserted mid-settle at level 3: all strobes 0 immediately, turbo_cur=0, cpu_en=1.
